// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared field widths, colour codes, scan states and LED bus packing
package game_pkg;

  localparam int ROW_W   = 4;
  localparam int COL_W   = 3;
  localparam int CLR_W   = 2;
  localparam int COL_MAX = 7;
  localparam int ROW_MAX = 15;

  localparam logic [CLR_W-1:0] CLR_OFF  = 2'b00;
  localparam logic [CLR_W-1:0] CLR_BALL = 2'b01;
  localparam logic [CLR_W-1:0] CLR_BAR  = 2'b10;

  typedef enum logic [1:0] {LATCH, DRAW, BLANK} scan_state_e;

  // Bit 7 of the matrix bus is unused by the board and is always driven low.
  function automatic logic [9:0] pack_led(input logic [CLR_W-1:0] clr,
                                          input logic [ROW_W-1:0] row,
                                          input logic [COL_W-1:0] col);
    return {clr, 1'b0, row, col};
  endfunction

endpackage

// File: rtl/slot_prescaler.sv
// rtl/slot_prescaler.sv - DWELL-cycle slot counter with hold-to-zero and last-cycle tick
module slot_prescaler #(
  parameter int DWELL = 2000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hold_i,
  output logic tick_o
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (hold_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/led_scan_arbiter.sv
// rtl/led_scan_arbiter.sv - frame scheduler that snapshots sprite runs and emits one pixel per slot
module led_scan_arbiter
  import game_pkg::*;
#(
  parameter int DWELL       = 2000,
  parameter int FRAME_SLOTS = 128,
  parameter int N_REQ       = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [7:0]       req_colour,
  input  logic [15:0]      req_row,
  input  logic [11:0]      req_col,
  input  logic [7:0]       req_len,
  output logic [9:0]       LEDout,
  output logic             frame_start,
  output logic             slot_tick
);

  localparam int SW = $clog2(FRAME_SLOTS);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME_SLOTS - 1);

  scan_state_e      state_q;
  logic [9:0]       led_q;
  logic             frame_start_q;
  logic [SW-1:0]    slot_q;
  logic [1:0]       cur_q;
  logic [1:0]       pix_q;
  logic [N_REQ-1:0] snap_valid_q;
  logic [7:0]       snap_colour_q;
  logic [15:0]      snap_row_q;
  logic [11:0]      snap_col_q;
  logic [7:0]       snap_len_q;

  logic       tick;
  logic       hold;
  logic [2:0] first_sel;
  logic [2:0] next_sel;
  logic [9:0] first_pix;
  logic [9:0] adv_pix;
  logic [9:0] next_pix;
  logic [1:0] cur_len;

  // Lowest-index valid requester at or above start; MSB flags a hit.
  function automatic logic [2:0] find_from(input logic [3:0] v, input logic [2:0] start);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (v[i] && 3'(i) >= start) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Pixels past column 7 are blanked rather than wrapped, but still use their slot.
  function automatic logic [9:0] pixel_of(input logic [1:0] clr, input logic [3:0] row,
                                          input logic [2:0] col, input logic [1:0] j);
    logic [3:0] x;
    logic [9:0] p;
    x = {1'b0, col} + {2'b00, j};
    p = pack_led(clr, row, x[2:0]);
    if (x > 4'(COL_MAX)) p = '0;
    return p;
  endfunction

  assign hold = !en || (state_q == LATCH);

  slot_prescaler #(.DWELL(DWELL)) u_prescaler (
    .clk_i (CLK),
    .rst_i (RST),
    .hold_i(hold),
    .tick_o(tick)
  );

  always_comb begin
    first_sel = find_from(req_valid, 3'd0);
    first_pix = pixel_of(req_colour[{first_sel[1:0], 1'b0} +: 2],
                         req_row[{first_sel[1:0], 2'b00} +: 4],
                         req_col[{2'b00, first_sel[1:0]} * 4'd3 +: 3], 2'd0);
    cur_len   = snap_len_q[{cur_q, 1'b0} +: 2];
    adv_pix   = pixel_of(snap_colour_q[{cur_q, 1'b0} +: 2],
                         snap_row_q[{cur_q, 2'b00} +: 4],
                         snap_col_q[{2'b00, cur_q} * 4'd3 +: 3], pix_q + 2'd1);
    next_sel  = find_from(snap_valid_q, {1'b0, cur_q} + 3'd1);
    next_pix  = pixel_of(snap_colour_q[{next_sel[1:0], 1'b0} +: 2],
                         snap_row_q[{next_sel[1:0], 2'b00} +: 4],
                         snap_col_q[{2'b00, next_sel[1:0]} * 4'd3 +: 3], 2'd0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= LATCH;
      led_q         <= '0;
      frame_start_q <= 1'b0;
      slot_q        <= '0;
      cur_q         <= '0;
      pix_q         <= '0;
      snap_valid_q  <= '0;
      snap_colour_q <= '0;
      snap_row_q    <= '0;
      snap_col_q    <= '0;
      snap_len_q    <= '0;
    end else begin
      frame_start_q <= 1'b0;
      if (!en) begin
        state_q <= LATCH;
        led_q   <= '0;
        slot_q  <= '0;
      end else begin
        case (state_q)
          LATCH: begin
            snap_valid_q  <= req_valid;
            snap_colour_q <= req_colour;
            snap_row_q    <= req_row;
            snap_col_q    <= req_col;
            snap_len_q    <= req_len;
            frame_start_q <= 1'b1;
            slot_q        <= '0;
            cur_q         <= first_sel[1:0];
            pix_q         <= '0;
            if (first_sel[2]) begin
              state_q <= DRAW;
              led_q   <= first_pix;
            end else begin
              state_q <= BLANK;
              led_q   <= '0;
            end
          end
          DRAW: begin
            if (tick) begin
              slot_q <= slot_q + SW'(1);
              if (slot_q == LAST_SLOT) begin
                state_q <= LATCH;
                led_q   <= '0;
              end else if (pix_q < cur_len) begin
                pix_q <= pix_q + 2'd1;
                led_q <= adv_pix;
              end else if (next_sel[2]) begin
                cur_q <= next_sel[1:0];
                pix_q <= '0;
                led_q <= next_pix;
              end else begin
                state_q <= BLANK;
                led_q   <= '0;
              end
            end
          end
          BLANK: begin
            led_q <= '0;
            if (tick) begin
              slot_q <= slot_q + SW'(1);
              if (slot_q == LAST_SLOT) state_q <= LATCH;
            end
          end
          default: begin
            state_q <= LATCH;
            led_q   <= '0;
          end
        endcase
      end
    end
  end

  assign LEDout      = led_q;
  assign frame_start = frame_start_q;
  assign slot_tick   = tick;

endmodule

// File: tb/tb_led_scan_arbiter.sv
// tb/tb_led_scan_arbiter.sv - directed vector bench for led_scan_arbiter with DWELL=4, FRAME_SLOTS=16
module tb_led_scan_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_colour = '0;
  logic [15:0] req_row = '0;
  logic [11:0] req_col = '0;
  logic [7:0]  req_len = '0;
  logic [9:0]  LEDout;
  logic        frame_start;
  logic        slot_tick;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0]       valid;
    logic [7:0]       colour;
    logic [15:0]      row;
    logic [11:0]      col;
    logic [7:0]       len;
    logic [15:0][9:0] exp;
  } vec_t;

  vec_t vecs [5];

  led_scan_arbiter #(.DWELL(4), .FRAME_SLOTS(16), .N_REQ(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .en         (en),
    .req_valid  (req_valid),
    .req_colour (req_colour),
    .req_row    (req_row),
    .req_col    (req_col),
    .req_len    (req_len),
    .LEDout     (LEDout),
    .frame_start(frame_start),
    .slot_tick  (slot_tick)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input int vi);
    req_valid  = vecs[vi].valid;
    req_colour = vecs[vi].colour;
    req_row    = vecs[vi].row;
    req_col    = vecs[vi].col;
    req_len    = vecs[vi].len;
  endtask

  // Caller releases RST at a negedge; the next posedge performs LATCH.
  task automatic run_frame(input int vi);
    logic [9:0] e_led;
    for (int k = 0; k < 66; k++) begin
      @(negedge CLK);
      e_led = (k < 64) ? vecs[vi].exp[k / 4] : ((k == 65) ? vecs[vi].exp[0] : 10'h000);
      check($sformatf("v%0d led k=%0d", vi, k), 32'(LEDout), 32'(e_led));
      check($sformatf("v%0d fs k=%0d", vi, k), 32'(frame_start), 32'(k == 0 || k == 65));
      check($sformatf("v%0d tick k=%0d", vi, k), 32'(slot_tick), 32'(k < 64 && (k % 4) == 3));
    end
  endtask

  task automatic reset_with(input int vi);
    @(negedge CLK);
    RST = 1'b1;
    en  = 1'b1;
    apply(vi);
    @(negedge CLK);
    check("reset led", 32'(LEDout), 32'h0);
    check("reset fs", 32'(frame_start), 32'h0);
    check("reset tick", 32'(slot_tick), 32'h0);
    RST = 1'b0;
  endtask

  initial begin
    vecs[0].valid = 4'b0001; vecs[0].colour = 8'b00_00_00_10;
    vecs[0].row = {12'h000, 4'd12}; vecs[0].col = {9'd0, 3'd4}; vecs[0].len = {6'd0, 2'd2};
    vecs[0].exp = '0;
    vecs[0].exp[0] = 10'h264; vecs[0].exp[1] = 10'h265; vecs[0].exp[2] = 10'h266;

    vecs[1].valid = 4'b0101; vecs[1].colour = 8'b00_01_11_10;
    vecs[1].row = {4'd0, 4'd5, 4'd1, 4'd12}; vecs[1].col = {3'd0, 3'd3, 3'd1, 3'd0};
    vecs[1].len = 8'h00;
    vecs[1].exp = '0;
    vecs[1].exp[0] = 10'h260; vecs[1].exp[1] = 10'h12B;

    vecs[2].valid = 4'b0010; vecs[2].colour = 8'b00_00_10_00;
    vecs[2].row = {8'h00, 4'd2, 4'd0}; vecs[2].col = {6'd0, 3'd6, 3'd0}; vecs[2].len = {4'd0, 2'd3, 2'd0};
    vecs[2].exp = '0;
    vecs[2].exp[0] = 10'h216; vecs[2].exp[1] = 10'h217;

    vecs[3].valid = 4'b0000; vecs[3].colour = 8'hFF;
    vecs[3].row = 16'hFFFF; vecs[3].col = 12'h000; vecs[3].len = 8'hFF;
    vecs[3].exp = '0;

    vecs[4].valid = 4'b1111; vecs[4].colour = 8'b11_00_10_01;
    vecs[4].row = {4'd9, 4'd3, 4'd15, 4'd0}; vecs[4].col = {3'd1, 3'd5, 3'd0, 3'd7};
    vecs[4].len = {2'd2, 2'd0, 2'd3, 2'd1};
    vecs[4].exp = '0;
    vecs[4].exp[0] = 10'h107; vecs[4].exp[1] = 10'h000; vecs[4].exp[2] = 10'h278;
    vecs[4].exp[3] = 10'h279; vecs[4].exp[4] = 10'h27A; vecs[4].exp[5] = 10'h27B;
    vecs[4].exp[6] = 10'h01D; vecs[4].exp[7] = 10'h349; vecs[4].exp[8] = 10'h34A;
    vecs[4].exp[9] = 10'h34B;

    for (int vi = 0; vi < 5; vi++) begin
      reset_with(vi);
      run_frame(vi);
    end

    // Mid-frame column change must not tear the current frame.
    reset_with(0);
    for (int k = 0; k < 70; k++) begin
      @(negedge CLK);
      if (k == 1) req_col = {9'd0, 3'd0};
      if (k == 5) check("midchg slot1", 32'(LEDout), 32'h265);
      if (k == 9) check("midchg slot2", 32'(LEDout), 32'h266);
      if (k == 65) begin
        check("midchg fs", 32'(frame_start), 32'h1);
        check("midchg new0", 32'(LEDout), 32'h260);
      end
      if (k == 69) check("midchg new1", 32'(LEDout), 32'h261);
    end

    // Enable drop mid-DRAW blanks next cycle and suppresses frame_start.
    reset_with(0);
    for (int k = 0; k < 6; k++) @(negedge CLK);
    check("en pre", 32'(LEDout), 32'h265);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check($sformatf("en0 led %0d", k), 32'(LEDout), 32'h0);
      check($sformatf("en0 fs %0d", k), 32'(frame_start), 32'h0);
      check($sformatf("en0 tick %0d", k), 32'(slot_tick), 32'h0);
    end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check($sformatf("reen fs %0d", k), 32'(frame_start), 32'(k == 0));
      check($sformatf("reen led %0d", k), 32'(LEDout), (k < 4) ? 32'h264 : 32'h265);
    end

    // Asynchronous reset mid-slot, then the post-reset sequence repeats.
    reset_with(1);
    for (int k = 0; k < 6; k++) @(negedge CLK);
    check("rst pre", 32'(LEDout), 32'h12B);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("rst async led", 32'(LEDout), 32'h0);
    check("rst async fs", 32'(frame_start), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    run_frame(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
